// File: rtl/alu_operand_stage_if.sv
// Issue-side instruction bus of the ALU operand stage.
// The master offers decoded instructions and the slave accepts them via in_ready.
interface alu_operand_stage_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_opcode;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic [ADDR_WIDTH-1:0] in_rs1;
  logic [ADDR_WIDTH-1:0] in_rs2;
  logic                  in_use_imm;
  logic [DATA_WIDTH-1:0] in_imm;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    output in_ready
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Issue/writeback wrapper around the combinational ALU: register file with
// forwarding, ex-stage operand registers, result capture and divide-by-zero trap.
module alu_operand_stage #(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    REG_COUNT       = 8,
  parameter bit                    R0_ZERO         = 1'b1,
  parameter bit                    HALT_ON_DIVZERO = 1'b1,
  parameter logic [DATA_WIDTH-1:0] DIVZERO_VALUE   = 8'hFF
) (
  input  logic                           clk,
  input  logic                           rst,
  alu_operand_stage_if.slave             iss,
  output logic [3:0]                     alu_opcode,
  output logic [DATA_WIDTH-1:0]          alu_a,
  output logic [DATA_WIDTH-1:0]          alu_b,
  input  logic [DATA_WIDTH-1:0]          alu_result,
  output logic                           wb_valid,
  output logic [$clog2(REG_COUNT)-1:0]   wb_rd,
  output logic [DATA_WIDTH-1:0]          wb_data,
  input  logic [$clog2(REG_COUNT)-1:0]   dbg_addr,
  output logic [DATA_WIDTH-1:0]          dbg_data,
  output logic                           div_zero,
  input  logic                           div_zero_clr
);
  localparam int AW = $clog2(REG_COUNT);
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};
  localparam logic [AW-1:0]         ZERO_ADDR = {AW{1'b0}};

  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                state_r, state_next_s;
  logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
  logic                  ex_valid_r;
  logic [AW-1:0]         ex_rd_r;
  logic                  wb_valid_r;
  logic [AW-1:0]         wb_rd_r;
  logic [DATA_WIDTH-1:0] wb_data_r;
  logic                  div_zero_r;
  logic [3:0]            alu_opcode_r;
  logic [DATA_WIDTH-1:0] alu_a_r, alu_b_r;

  logic                  accept_s, div_zero_s;
  logic                  rs1_zero_s, rs2_zero_s, fwd_a_s, fwd_b_s, rd_wr_s;
  logic [DATA_WIDTH-1:0] result_s, op_a_s, op_b_s, reg_b_s;

  assign iss.in_ready = (state_r == RUN) && !rst;
  assign accept_s     = iss.in_valid && iss.in_ready;

  // Trap detection and result substitution for the instruction in the ex stage
  always_comb begin
    div_zero_s = ex_valid_r && ((alu_opcode_r == 4'b0011) || (alu_opcode_r == 4'b1100))
                 && (alu_b_r == ZERO_DATA);
    result_s   = div_zero_s ? DIVZERO_VALUE : alu_result;
    rd_wr_s    = ex_valid_r && !(R0_ZERO && (ex_rd_r == ZERO_ADDR));
  end

  // Operand resolution; only the ex-stage result is forwarded, never r0
  always_comb begin
    rs1_zero_s = R0_ZERO && (iss.in_rs1 == ZERO_ADDR);
    rs2_zero_s = R0_ZERO && (iss.in_rs2 == ZERO_ADDR);
    fwd_a_s    = ex_valid_r && (ex_rd_r == iss.in_rs1) && !rs1_zero_s;
    fwd_b_s    = ex_valid_r && (ex_rd_r == iss.in_rs2) && !rs2_zero_s;
    op_a_s     = fwd_a_s ? result_s : (rs1_zero_s ? ZERO_DATA : regs_r[iss.in_rs1]);
    reg_b_s    = fwd_b_s ? result_s : (rs2_zero_s ? ZERO_DATA : regs_r[iss.in_rs2]);
    op_b_s     = iss.in_use_imm ? iss.in_imm : reg_b_s;
  end

  // Ex-stage registers; an empty stage presents all-zero operands to the ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r   <= 1'b0;
      ex_rd_r      <= ZERO_ADDR;
      alu_opcode_r <= 4'b0000;
      alu_a_r      <= ZERO_DATA;
      alu_b_r      <= ZERO_DATA;
    end else if (accept_s) begin
      ex_valid_r   <= 1'b1;
      ex_rd_r      <= iss.in_rd;
      alu_opcode_r <= iss.in_opcode;
      alu_a_r      <= op_a_s;
      alu_b_r      <= op_b_s;
    end else begin
      ex_valid_r   <= 1'b0;
      ex_rd_r      <= ZERO_ADDR;
      alu_opcode_r <= 4'b0000;
      alu_a_r      <= ZERO_DATA;
      alu_b_r      <= ZERO_DATA;
    end
  end

  // Writeback capture and register-file update at the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_r <= 1'b0;
      wb_rd_r    <= ZERO_ADDR;
      wb_data_r  <= ZERO_DATA;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= ZERO_DATA;
      end
    end else begin
      wb_valid_r <= ex_valid_r;
      if (ex_valid_r) begin
        wb_rd_r   <= ex_rd_r;
        wb_data_r <= result_s;
      end
      if (rd_wr_s) begin
        regs_r[ex_rd_r] <= result_s;
      end
    end
  end

  // Sticky divide-by-zero flag; a new trap wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_zero_r <= 1'b0;
    end else if (div_zero_s) begin
      div_zero_r <= 1'b1;
    end else if (div_zero_clr) begin
      div_zero_r <= 1'b0;
    end
  end

  // Issue-control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Issue-control next state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (div_zero_s && HALT_ON_DIVZERO) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      HALT: begin
        if (div_zero_s && HALT_ON_DIVZERO) begin
          state_next_s = HALT;
        end else if (div_zero_clr) begin
          state_next_s = RUN;
        end else begin
          state_next_s = HALT;
        end
      end
      default: state_next_s = RUN;
    endcase
  end

  assign alu_opcode = alu_opcode_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign wb_valid   = wb_valid_r;
  assign wb_rd      = wb_rd_r;
  assign wb_data    = wb_data_r;
  assign div_zero   = div_zero_r;
  assign dbg_data   = (R0_ZERO && (dbg_addr == ZERO_ADDR)) ? ZERO_DATA : regs_r[dbg_addr];
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: a behavioural ALU closes the loop, a vector table
// covers forwarding/pipelining, and directed sequences cover trap, halt and reset.
module tb_alu_operand_stage;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010,
                         OP_DIV = 4'b0011, OP_UND = 4'b0101, OP_MOD = 4'b1100;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic       wb_valid, div_zero, div_zero_clr;
  logic [2:0] wb_rd, dbg_addr;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) iss ();

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .iss(iss),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .div_zero(div_zero), .div_zero_clr(div_zero_clr)
  );

  // Stand-in combinational ALU; div/mod by zero return 0 so substitution is visible
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a * b;
      4'b0011: return (b == 8'h00) ? 8'h00 : a / b;
      4'b0100: return a & b;
      4'b0110: return a | b;
      4'b0111: return a ^ b;
      4'b1000: return a << b[2:0];
      4'b1001: return a >> b[2:0];
      4'b1010: return ~a;
      4'b1100: return (b == 8'h00) ? 8'h00 : a % b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_opcode, alu_a, alu_b);

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    logic       use_imm;
    logic [7:0] imm;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic use_imm, input logic [7:0] imm);
    iss.in_valid   = 1'b1;
    iss.in_opcode  = op;
    iss.in_rd      = rd;
    iss.in_rs1     = rs1;
    iss.in_rs2     = rs2;
    iss.in_use_imm = use_imm;
    iss.in_imm     = imm;
  endtask

  task automatic idle();
    iss.in_valid = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(name, dbg_data, exp);
  endtask

  initial begin
    // op, rd, rs1, rs2, use_imm, imm, expected wb_data
    vec[0] = '{OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 8'h05};
    vec[1] = '{OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h03, 8'h03};
    vec[2] = '{OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00, 8'h06};  // both operands forwarded
    vec[3] = '{OP_SUB, 3'd3, 3'd2, 3'd0, 1'b1, 8'h01, 8'h05};
    vec[4] = '{OP_ADD, 3'd6, 3'd1, 3'd3, 1'b0, 8'h00, 8'h08};  // r1 from regfile, r3 forwarded
    vec[5] = '{OP_UND, 3'd7, 3'd6, 3'd0, 1'b1, 8'h09, 8'h00};
    vec[6] = '{OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 8'h09, 8'h09};
    vec[7] = '{OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 8'h01, 8'h01};  // r0 in ex must not forward
    vec[8] = '{OP_MUL, 3'd7, 3'd6, 3'd0, 1'b1, 8'h02, 8'h10};
    vec[9] = '{OP_MOD, 3'd4, 3'd6, 3'd0, 1'b1, 8'h03, 8'h02};

    rst = 1'b1;
    div_zero_clr = 1'b0;
    dbg_addr = 3'd0;
    drive(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    idle();
    step();
    step();
    check("rst_in_ready", iss.in_ready, 1'b0);
    check("rst_alu_opcode", alu_opcode, 4'h0);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_rd", wb_rd, 3'd0);
    check("rst_wb_data", wb_data, 8'h00);
    check("rst_div_zero", div_zero, 1'b0);
    rst = 1'b0;
    #1;
    check("run_in_ready", iss.in_ready, 1'b1);

    // Back-to-back issue; result of vector k-1 is visible right after edge k
    step();
    for (int k = 0; k <= NV; k++) begin
      if (k < NV) drive(vec[k].op, vec[k].rd, vec[k].rs1, vec[k].rs2, vec[k].use_imm, vec[k].imm);
      else idle();
      step();
      if (k == 0) begin
        check("v0_alu_b", alu_b, 8'h05);
      end
      if (k >= 1) begin
        check($sformatf("v%0d_wb_valid", k-1), wb_valid, 1'b1);
        check($sformatf("v%0d_wb_rd", k-1), wb_rd, vec[k-1].rd);
        check($sformatf("v%0d_wb_data", k-1), wb_data, vec[k-1].exp);
      end
    end
    step();
    check("tbl_wb_idle", wb_valid, 1'b0);
    check_reg("tbl_r0", 3'd0, 8'h00);
    check_reg("tbl_r1", 3'd1, 8'h03);
    check_reg("tbl_r2", 3'd2, 8'h06);
    check_reg("tbl_r3", 3'd3, 8'h05);
    step();
    check_reg("tbl_r4", 3'd4, 8'h02);
    check_reg("tbl_r5", 3'd5, 8'h01);
    check_reg("tbl_r6", 3'd6, 8'h08);
    check_reg("tbl_r7", 3'd7, 8'h10);
    check("tbl_div_zero", div_zero, 1'b0);

    // Divide by zero halts issue until cleared
    step();
    drive(OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 8'h07);
    step();
    drive(OP_DIV, 3'd4, 3'd3, 3'd0, 1'b1, 8'h00);
    step();
    check("dz_r3_wb", wb_data, 8'h07);
    idle();
    step();
    check("dz_wb_valid", wb_valid, 1'b1);
    check("dz_wb_rd", wb_rd, 3'd4);
    check("dz_wb_data", wb_data, 8'hFF);
    check("dz_flag", div_zero, 1'b1);
    check("dz_in_ready", iss.in_ready, 1'b0);
    drive(OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 8'h22);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("halt%0d_in_ready", i), iss.in_ready, 1'b0);
      check($sformatf("halt%0d_no_wb", i), wb_valid, 1'b0);
    end
    div_zero_clr = 1'b1;
    step();
    div_zero_clr = 1'b0;
    check("clr_in_ready", iss.in_ready, 1'b1);
    check("clr_flag", div_zero, 1'b0);
    step();
    idle();
    step();
    check("resume_wb_valid", wb_valid, 1'b1);
    check("resume_wb_rd", wb_rd, 3'd5);
    check("resume_wb_data", wb_data, 8'h22);
    check_reg("dz_r4", 3'd4, 8'hFF);

    // Clear coinciding with a new mod-by-zero capture: set wins
    step();
    drive(OP_MOD, 3'd6, 3'd5, 3'd0, 1'b1, 8'h00);
    step();
    idle();
    div_zero_clr = 1'b1;
    step();
    div_zero_clr = 1'b0;
    check("sc_flag", div_zero, 1'b1);
    check("sc_in_ready", iss.in_ready, 1'b0);
    check("sc_wb_rd", wb_rd, 3'd6);
    check("sc_wb_data", wb_data, 8'hFF);
    step();
    check("sc_still_halt", iss.in_ready, 1'b0);
    div_zero_clr = 1'b1;
    step();
    div_zero_clr = 1'b0;
    check("sc_release", iss.in_ready, 1'b1);
    check("sc_cleared", div_zero, 1'b0);

    // Reset with an instruction in flight discards it
    drive(OP_MOD, 3'd7, 3'd1, 3'd0, 1'b1, 8'h00);
    step();
    drive(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 8'h44);
    step();
    check("mr_pre_flag", div_zero, 1'b1);
    rst = 1'b1;
    idle();
    #1;
    check("mr_in_ready", iss.in_ready, 1'b0);
    check("mr_wb_valid", wb_valid, 1'b0);
    check("mr_flag", div_zero, 1'b0);
    check("mr_alu_b", alu_b, 8'h00);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mr%0d_no_wb", i), wb_valid, 1'b0);
    end
    check_reg("mr_r1", 3'd1, 8'h00);
    check_reg("mr_r2", 3'd2, 8'h00);
    check_reg("mr_r4", 3'd4, 8'h00);
    check_reg("mr_r5", 3'd5, 8'h00);
    check("mr_run", iss.in_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue/writeback wrapper around the 8-bit combinational ALU. Sits directly upstream of the ALU and also consumes its result.
- Accepts decoded register-form or immediate-form ALU instructions over a valid/ready handshake.
- Reads operands from an internal 8x8 register file, with forwarding, and registers opcode/a/b into the ALU.
- Captures the ALU result one cycle later, writes it back, traps divide/modulo by zero, and optionally halts issue.

Parameters:
- DATA_WIDTH, 8, operand/result width. Must match ALU.
- REG_COUNT, 8, number of architectural registers. Address width is clog2(REG_COUNT) = 3.
- R0_ZERO, 1, 1: r0 reads as 0 and writes to it are discarded.
- HALT_ON_DIVZERO, 1, 1: a divide-by-zero event stops issue until cleared.
- DIVZERO_VALUE, 8'hFF, value substituted for the result of div/mod by zero.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block accepts instruction this cycle
- in_opcode  in  4  ALU opcode (ALU encoding)
- in_rd  in  3  destination register
- in_rs1  in  3  source register for operand a
- in_rs2  in  3  source register for operand b (ignored when in_use_imm=1)
- in_use_imm  in  1  1: operand b = in_imm
- in_imm  in  8  immediate operand
- alu_opcode  out  4  registered opcode to ALU
- alu_a  out  8  registered operand a to ALU
- alu_b  out  8  registered operand b to ALU
- alu_result  in  8  combinational ALU result
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_rd  out  3  retired destination register
- wb_data  out  8  retired result (after div-zero substitution)
- dbg_addr  in  3  debug read address
- dbg_data  out  8  combinational register-file read at dbg_addr, with R0_ZERO applied
- div_zero  out  1  sticky divide-by-zero flag
- div_zero_clr  in  1  clears div_zero and leaves HALT

Behaviour:
- Reset (async, rst=1):
  - All registers r0..r7 = 0; state = RUN.
  - Ex stage and wb stage invalid.
  - alu_opcode/alu_a/alu_b = 0; wb_valid = 0, wb_rd = 0, wb_data = 0.
  - div_zero = 0; in_ready = 0 while rst is high.
- Two-stage pipeline, throughput 1 per cycle:
  - Cycle N: handshake (in_valid & in_ready). Operands are resolved and latched into the ex stage at edge N→N+1.
  - Cycle N+1: ALU evaluates. At edge N+1→N+2 the result is written to the register file and to wb_rd/wb_data.
  - wb_valid is high during cycle N+2 only.
- Ex stage empty: alu_opcode/alu_a/alu_b are driven 0 and nothing is written back.
- Operand resolution, in cycle N:
  - Operand a = regfile[rs1]. Operand b = in_imm if in_use_imm, else regfile[rs2].
  - If the ex stage is valid and ex_rd equals the source register (and the register is not r0 with R0_ZERO=1), the current-cycle result (post-substitution) is forwarded instead of the regfile value.
  - No other forwarding: the regfile write lands at the same edge as the wb capture.
- Division by zero:
  - Condition: ex-stage opcode is 4'b0011 (div) or 4'b1100 (mod) and alu_b == 0.
  - Result is replaced by DIVZERO_VALUE; the ALU output is ignored.
  - div_zero is set at the capture edge.
- Undefined opcodes (0101, 1011, 1101-1111): the ALU result (0) is written normally. No error.
- r0 writes with R0_ZERO=1: regfile is unchanged, wb_valid still pulses, and wb_data shows the computed value.
- State machine:
  - RUN: in_ready = 1. On a divide-by-zero capture with HALT_ON_DIVZERO=1, go to HALT at that edge.
  - HALT: in_ready = 0. The in-flight ex instruction (if any) still completes. div_zero_clr=1 → RUN next edge, with div_zero cleared.
  - div_zero_clr in RUN clears the flag.
  - A simultaneous set and clear leaves div_zero=1 (set wins) and the state stays/enters HALT.
- Reset mid-operation: in-flight instructions are discarded, no write occurs, and all state returns to its reset values.

Test Plan:
1. Reset, then issue r1 = 0 + imm 5 (opcode 0000, rs1=0, imm=5) → wb_valid 2 cycles after accept, wb_rd=1, wb_data=8'h05; dbg_addr=1 reads 8'h05.
2. Back-to-back r1 = r0+imm 3, then r2 = r1+r1 → second instruction uses forwarded 3; wb_data=8'h06 with no bubble; wb_valid high in 2 consecutive cycles.
3. r3 = imm 7, then div r4 = r3 / imm 0 → wb_data=8'hFF, div_zero=1, in_ready=0 from next cycle; held offer is not accepted for 5 cycles; pulse div_zero_clr → in_ready=1 the following cycle and the offer is accepted.
4. Write to r0 with imm 9 → wb_valid=1, wb_data=8'h09; dbg_addr=0 reads 0; a following r5 = r0+imm 1 gives 8'h01 (no forwarding from r0).
5. Assert rst in the cycle after accepting an instruction → no wb_valid pulse, all registers 0, div_zero=0.
6. div_zero_clr asserted in the same cycle as a new div-by-zero capture → div_zero stays 1 and state is HALT.
